// File: rtl/altera_tse_rx_mon_pkg.sv
// Shared types and constants for the GMII receive frame monitor:
// FSM states, register map, GMII framing bytes and CRC-32 helpers.
package altera_tse_rx_mon_pkg;

  typedef enum logic [2:0] {
    ST_SYNC_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DROP      = 3'd4
  } rx_state_e;

  // Register map
  localparam logic [2:0] ADDR_GOOD     = 3'd0;
  localparam logic [2:0] ADDR_RUNT     = 3'd1;
  localparam logic [2:0] ADDR_OVERSIZE = 3'd2;
  localparam logic [2:0] ADDR_ERR      = 3'd3;
  localparam logic [2:0] ADDR_SFD_ERR  = 3'd4;
  localparam logic [2:0] ADDR_OCTETS   = 3'd5;
  localparam logic [2:0] ADDR_CRC_ERR  = 3'd6;

  // Per-frame event counters share one generate loop; indices match the register map.
  localparam int CNT_GOOD      = 0;
  localparam int CNT_RUNT      = 1;
  localparam int CNT_OVERSIZE  = 2;
  localparam int CNT_ERR       = 3;
  localparam int CNT_SFD_ERR   = 4;
  localparam int NUM_FRAME_CNT = 5;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first (reflected) CRC-32 update over one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = bit_rev32(CRC_POLY);
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/altera_tse_rx_mon_sat_cnt.sv
// Saturating statistics counter: adds i_step when i_inc, sticks at all-ones,
// and i_clr wins over a simultaneous increment.
module altera_tse_rx_mon_sat_cnt #(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  input  logic [STEP_WIDTH-1:0] i_step,
  output logic [WIDTH-1:0]      o_count
);

  localparam int SUM_W = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;

  logic [WIDTH-1:0] r_count;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_max;

  assign w_sum = SUM_W'(r_count) + SUM_W'(i_step);
  assign w_max = SUM_W'({WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= (w_sum > w_max) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/altera_tse_gmii_rx_frame_monitor.sv
// Passive GMII receive frame monitor: delineates, measures and classifies frames
// and keeps saturating statistics. Optional CRC check: define TSE_RX_MON_CRC_EN.
module altera_tse_gmii_rx_frame_monitor
  import altera_tse_rx_mon_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           gmii_rx_d,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_err,
  input  logic                 rx_clkena,
  input  logic                 clear,
  input  logic [2:0]           address,
  input  logic                 read,
  output logic [CNT_WIDTH-1:0] readdata,
  output logic                 frame_done,
  output logic [15:0]          frame_len,
  output logic                 frame_good
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  rx_state_e r_state;
  rx_state_e w_state_next;

  logic        w_start;
  logic        w_eof;
  logic        w_sfd_inc;
  logic        w_data_byte;
  logic [15:0] r_len;
  logic        r_err_flag;

  logic r_frame_done;
  logic [15:0] r_frame_len;
  logic r_frame_good;
  logic [CNT_WIDTH-1:0] r_readdata;

  logic w_crc_bad;
  logic w_cls_runt;
  logic w_cls_over;
  logic w_cls_good;

  logic [NUM_FRAME_CNT-1:0] w_evt_inc;
  logic [CNT_WIDTH-1:0]     w_cnt [NUM_FRAME_CNT];
  logic [CNT_WIDTH-1:0]     w_octets;
  logic [CNT_WIDTH-1:0]     w_crc_cnt;
  logic [CNT_WIDTH-1:0]     w_rd_mux;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_SYNC_WAIT;
    else          r_state <= w_state_next;
  end

  // All transitions are qualified by rx_clkena so 10/100 byte pacing is honoured.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_eof        = 1'b0;
    w_sfd_inc    = 1'b0;
    if (rx_clkena) begin
      case (r_state)
        ST_SYNC_WAIT: begin
          if (!gmii_rx_dv) w_state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_d == PREAMBLE_BYTE) begin
              w_state_next = ST_PREAMBLE;
            end else if (gmii_rx_d == SFD_BYTE) begin
              w_state_next = ST_DATA;
              w_start      = 1'b1;
            end else begin
              w_state_next = ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            w_state_next = ST_IDLE;
            w_sfd_inc    = 1'b1;
          end else if (gmii_rx_err) begin
            w_state_next = ST_DROP;
          end else if (gmii_rx_d == SFD_BYTE) begin
            w_state_next = ST_DATA;
            w_start      = 1'b1;
          end else if (gmii_rx_d != PREAMBLE_BYTE) begin
            w_state_next = ST_DROP;
          end
        end
        ST_DATA: begin
          if (!gmii_rx_dv) begin
            w_state_next = ST_IDLE;
            w_eof        = 1'b1;
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) begin
            w_state_next = ST_IDLE;
            w_sfd_inc    = 1'b1;
          end
        end
        default: w_state_next = ST_SYNC_WAIT;
      endcase
    end
  end

  assign w_data_byte = (r_state == ST_DATA) && rx_clkena && gmii_rx_dv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_err_flag <= 1'b0;
    end else if (w_start) begin
      r_len      <= '0;
      r_err_flag <= 1'b0;
    end else if (w_data_byte) begin
      if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
      if (gmii_rx_err)       r_err_flag <= 1'b1;
    end
  end

`ifdef TSE_RX_MON_CRC_EN
  logic [31:0] r_crc;

  always_ff @(posedge clk) begin
    if (!reset_n || w_start) r_crc <= CRC_INIT;
    else if (w_data_byte)    r_crc <= crc32_byte(r_crc, gmii_rx_d);
  end

  // Residue constant is stored MSB-first; the register shifts LSB-first.
  assign w_crc_bad = (bit_rev32(r_crc) != CRC_RESIDUE);

  altera_tse_rx_mon_sat_cnt #(
    .WIDTH      (CNT_WIDTH),
    .STEP_WIDTH (1)
  ) u_crc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clear),
    .i_inc   (w_eof && !r_err_flag && w_crc_bad),
    .i_step  (1'b1),
    .o_count (w_crc_cnt)
  );
`else
  assign w_crc_bad = 1'b0;
  assign w_crc_cnt = '0;
`endif

  // Priority: GMII error, then CRC, then length checks.
  assign w_cls_runt = !r_err_flag && !w_crc_bad && (r_len < MIN_LEN);
  assign w_cls_over = !r_err_flag && !w_crc_bad && (r_len > MAX_LEN);
  assign w_cls_good = !r_err_flag && !w_crc_bad && !(r_len < MIN_LEN) && !(r_len > MAX_LEN);

  assign w_evt_inc[CNT_GOOD]     = w_eof && w_cls_good;
  assign w_evt_inc[CNT_RUNT]     = w_eof && w_cls_runt;
  assign w_evt_inc[CNT_OVERSIZE] = w_eof && w_cls_over;
  assign w_evt_inc[CNT_ERR]      = w_eof && r_err_flag;
  assign w_evt_inc[CNT_SFD_ERR]  = w_sfd_inc;

  for (genvar gi = 0; gi < NUM_FRAME_CNT; gi++) begin : g_evt_cnt
    altera_tse_rx_mon_sat_cnt #(
      .WIDTH      (CNT_WIDTH),
      .STEP_WIDTH (1)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (clear),
      .i_inc   (w_evt_inc[gi]),
      .i_step  (1'b1),
      .o_count (w_cnt[gi])
    );
  end

  altera_tse_rx_mon_sat_cnt #(
    .WIDTH      (CNT_WIDTH),
    .STEP_WIDTH (16)
  ) u_octets_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clear),
    .i_inc   (w_eof),
    .i_step  (r_len),
    .o_count (w_octets)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_frame_len  <= '0;
      r_frame_good <= 1'b0;
    end else begin
      r_frame_done <= w_eof;
      if (w_eof) begin
        r_frame_len  <= r_len;
        r_frame_good <= w_cls_good;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_GOOD:     w_rd_mux = w_cnt[CNT_GOOD];
      ADDR_RUNT:     w_rd_mux = w_cnt[CNT_RUNT];
      ADDR_OVERSIZE: w_rd_mux = w_cnt[CNT_OVERSIZE];
      ADDR_ERR:      w_rd_mux = w_cnt[CNT_ERR];
      ADDR_SFD_ERR:  w_rd_mux = w_cnt[CNT_SFD_ERR];
      ADDR_OCTETS:   w_rd_mux = w_octets;
      ADDR_CRC_ERR:  w_rd_mux = w_crc_cnt;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  r_readdata <= '0;
    else if (read) r_readdata <= w_rd_mux;
  end

  assign readdata   = r_readdata;
  assign frame_done = r_frame_done;
  assign frame_len  = r_frame_len;
  assign frame_good = r_frame_good;

endmodule

// File: tb/tb_altera_tse_gmii_rx_frame_monitor.sv
// Directed bench for the GMII receive frame monitor (8-bit counters so
// saturation is reachable quickly).
module tb_altera_tse_gmii_rx_frame_monitor;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    gmii_rx_d = 8'h00;
  logic          gmii_rx_dv = 1'b0;
  logic          gmii_rx_err = 1'b0;
  logic          rx_clkena = 1'b1;
  logic          clear = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          read = 1'b0;
  logic [CW-1:0] readdata;
  logic          frame_done;
  logic [15:0]   frame_len;
  logic          frame_good;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  altera_tse_gmii_rx_frame_monitor #(
    .MIN_FRAME_LEN (64),
    .MAX_FRAME_LEN (1518),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .gmii_rx_d   (gmii_rx_d),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_err (gmii_rx_err),
    .rx_clkena   (rx_clkena),
    .clear       (clear),
    .address     (address),
    .read        (read),
    .readdata    (readdata),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .frame_good  (frame_good)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with frame_done high, so a stretched pulse shows up too.
  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic put(input logic dv, input logic [7:0] d, input logic err, input int gap);
    rx_clkena = 1'b1; gmii_rx_dv = dv; gmii_rx_d = d; gmii_rx_err = err;
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      rx_clkena = 1'b0;
      @(posedge clk); #1;
    end
    rx_clkena = 1'b1;
  endtask

  task automatic frame_body(input int npre, input int nbytes, input int err_at, input int gap);
    for (int i = 0; i < npre; i++) put(1'b1, 8'h55, 1'b0, gap);
    put(1'b1, 8'hD5, 1'b0, gap);
    for (int i = 0; i < nbytes; i++) put(1'b1, 8'((i * 7 + 3) & 255), (i == err_at), gap);
  endtask

  task automatic send_frame(input int npre, input int nbytes, input int err_at, input int gap);
    frame_body(npre, nbytes, err_at, gap);
    put(1'b0, 8'h00, 1'b0, gap);
    put(1'b0, 8'h00, 1'b0, gap);
    put(1'b0, 8'h00, 1'b0, gap);
    $display("frame: preamble=%0d data_len=%0d err_at=%0d gap=%0d -> len=%0d good=%0d",
             npre, nbytes, err_at, gap, frame_len, frame_good);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [CW-1:0] v);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    v = readdata;
    $display("read: addr=%0d data=0x%0h", a, v);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [CW-1:0] v;
    reset_n = 1'b0;
    repeat (3) put(1'b0, 8'h00, 1'b0, 0);
    n_cmp++; if (frame_done !== 1'b0) begin n_mis++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
    n_cmp++; if (frame_len !== 16'd0) begin n_mis++; $display("FAIL reset_frame_len: got %0d expected 0", frame_len); end
    n_cmp++; if (frame_good !== 1'b0) begin n_mis++; $display("FAIL reset_frame_good: got %0b expected 0", frame_good); end
    n_cmp++; if (readdata !== 8'h00) begin n_mis++; $display("FAIL reset_readdata: got 0x%0h expected 0x0", readdata); end
    reset_n = 1'b1;
    put(1'b0, 8'h00, 1'b0, 0);
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), v);
      n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL reset_counter[%0d]: got 0x%0h expected 0x0", a, v); end
    end
  endtask

  task automatic test_runt();
    logic [CW-1:0] v;
    int d0;
    d0 = done_cnt;
    send_frame(7, 60, -1, 0);
    n_cmp++; if (done_cnt !== d0 + 1) begin n_mis++; $display("FAIL runt_done: got %0d pulses expected 1", done_cnt - d0); end
    n_cmp++; if (frame_len !== 16'd60) begin n_mis++; $display("FAIL runt_len: got %0d expected 60", frame_len); end
    n_cmp++; if (frame_good !== 1'b0) begin n_mis++; $display("FAIL runt_good: got %0b expected 0", frame_good); end
    read_reg(3'd1, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL runt_count: got %0d expected 1", v); end
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL runt_good_count: got %0d expected 0", v); end
  endtask

  task automatic test_good();
    logic [CW-1:0] v;
    send_frame(7, 64, -1, 0);
    n_cmp++; if (frame_len !== 16'd64) begin n_mis++; $display("FAIL good_len: got %0d expected 64", frame_len); end
    n_cmp++; if (frame_good !== 1'b1) begin n_mis++; $display("FAIL good_flag: got %0b expected 1", frame_good); end
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL good_count: got %0d expected 1", v); end
    address = 3'd2;
    @(posedge clk); #1;
    n_cmp++; if (readdata !== 8'd1) begin n_mis++; $display("FAIL readdata_hold: got %0d expected 1", readdata); end
    read_reg(3'd5, v);
    n_cmp++; if (v !== 8'd124) begin n_mis++; $display("FAIL good_octets: got %0d expected 124", v); end
  endtask

  task automatic test_oversize();
    logic [CW-1:0] v;
    send_frame(7, 1519, -1, 0);
    n_cmp++; if (frame_len !== 16'd1519) begin n_mis++; $display("FAIL over_len: got %0d expected 1519", frame_len); end
    n_cmp++; if (frame_good !== 1'b0) begin n_mis++; $display("FAIL over_good: got %0b expected 0", frame_good); end
    read_reg(3'd2, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL over_count: got %0d expected 1", v); end
    read_reg(3'd5, v);
    n_cmp++; if (v !== 8'hFF) begin n_mis++; $display("FAIL octets_saturate: got 0x%0h expected 0xff", v); end
    send_frame(7, 1519, 10, 0);
    read_reg(3'd3, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL err_count: got %0d expected 1", v); end
    read_reg(3'd2, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL err_over_unchanged: got %0d expected 1", v); end
    n_cmp++; if (frame_good !== 1'b0) begin n_mis++; $display("FAIL err_good: got %0b expected 0", frame_good); end
  endtask

  task automatic test_sfd_err();
    logic [CW-1:0] v;
    int d0;
    d0 = done_cnt;
    repeat (3) put(1'b1, 8'h55, 1'b0, 0);
    put(1'b1, 8'h12, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    read_reg(3'd4, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL sfd_bad_byte: got %0d expected 1", v); end
    repeat (2) put(1'b1, 8'h55, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    read_reg(3'd4, v);
    n_cmp++; if (v !== 8'd2) begin n_mis++; $display("FAIL sfd_dv_drop: got %0d expected 2", v); end
    put(1'b1, 8'h55, 1'b0, 0);
    put(1'b1, 8'h55, 1'b1, 0);
    put(1'b1, 8'h55, 1'b0, 0);
    put(1'b1, 8'hD5, 1'b0, 0);
    repeat (70) put(1'b1, 8'hA5, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    read_reg(3'd4, v);
    n_cmp++; if (v !== 8'd3) begin n_mis++; $display("FAIL sfd_err_in_preamble: got %0d expected 3", v); end
    n_cmp++; if (done_cnt !== d0) begin n_mis++; $display("FAIL sfd_no_done: got %0d pulses expected 0", done_cnt - d0); end
    n_cmp++; if (frame_len !== 16'd1519) begin n_mis++; $display("FAIL frame_len_hold: got %0d expected 1519", frame_len); end
    read_reg(3'd6, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL addr6_zero: got %0d expected 0", v); end
    read_reg(3'd7, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL addr7_zero: got %0d expected 0", v); end
  endtask

  task automatic test_midframe_reset();
    logic [CW-1:0] v;
    int d0;
    frame_body(7, 20, -1, 0);
    reset_n = 1'b0;
    repeat (2) put(1'b1, 8'h3C, 1'b0, 0);
    reset_n = 1'b1;
    d0 = done_cnt;
    put(1'b1, 8'h55, 1'b0, 0);
    put(1'b1, 8'h55, 1'b0, 0);
    put(1'b1, 8'hD5, 1'b0, 0);
    repeat (30) put(1'b1, 8'h11, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    n_cmp++; if (done_cnt !== d0) begin n_mis++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt - d0); end
    for (int a = 0; a < 6; a++) begin
      read_reg(3'(a), v);
      n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL midreset_counter[%0d]: got %0d expected 0", a, v); end
    end
    send_frame(7, 64, -1, 0);
    n_cmp++; if (frame_good !== 1'b1) begin n_mis++; $display("FAIL midreset_next_good: got %0b expected 1", frame_good); end
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL midreset_good_count: got %0d expected 1", v); end
  endtask

  task automatic test_clkena();
    logic [CW-1:0] v;
    int d0;
    d0 = done_cnt;
    send_frame(7, 64, -1, 9);
    n_cmp++; if (done_cnt !== d0 + 1) begin n_mis++; $display("FAIL clkena_done_width: got %0d cycles expected 1", done_cnt - d0); end
    n_cmp++; if (frame_len !== 16'd64) begin n_mis++; $display("FAIL clkena_len: got %0d expected 64", frame_len); end
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd2) begin n_mis++; $display("FAIL clkena_good_count: got %0d expected 2", v); end
  endtask

  task automatic test_boundaries();
    logic [CW-1:0] v;
    send_frame(7, 63, -1, 0);
    n_cmp++; if (frame_good !== 1'b0) begin n_mis++; $display("FAIL len63_good: got %0b expected 0", frame_good); end
    read_reg(3'd1, v);
    n_cmp++; if (v !== 8'd1) begin n_mis++; $display("FAIL len63_runt: got %0d expected 1", v); end
    send_frame(0, 1518, -1, 0);
    n_cmp++; if (frame_good !== 1'b1) begin n_mis++; $display("FAIL len1518_good: got %0b expected 1", frame_good); end
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd3) begin n_mis++; $display("FAIL len1518_count: got %0d expected 3", v); end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] v;
    pulse_clear();
    read_reg(3'd0, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL clear_good: got %0d expected 0", v); end
    for (int n = 0; n < 300; n++) send_frame(0, 1, -1, 0);
    read_reg(3'd1, v);
    n_cmp++; if (v !== 8'hFF) begin n_mis++; $display("FAIL runt_saturate: got 0x%0h expected 0xff", v); end
    read_reg(3'd5, v);
    n_cmp++; if (v !== 8'hFF) begin n_mis++; $display("FAIL octets_after_300: got 0x%0h expected 0xff", v); end
  endtask

  task automatic test_clear_concurrent();
    logic [CW-1:0] v;
    int d0;
    frame_body(0, 10, -1, 0);
    clear = 1'b1;
    put(1'b0, 8'h00, 1'b0, 0);
    clear = 1'b0;
    put(1'b0, 8'h00, 1'b0, 0);
    read_reg(3'd1, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL clear_with_inc: got %0d expected 0", v); end
    d0 = done_cnt;
    frame_body(0, 10, -1, 0);
    put(1'b0, 8'h00, 1'b0, 0);
    clear = 1'b1;
    put(1'b0, 8'h00, 1'b0, 0);
    clear = 1'b0;
    put(1'b0, 8'h00, 1'b0, 0);
    n_cmp++; if (done_cnt !== d0 + 1) begin n_mis++; $display("FAIL clear_done_seen: got %0d pulses expected 1", done_cnt - d0); end
    read_reg(3'd1, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL clear_with_done: got %0d expected 0", v); end
    read_reg(3'd5, v);
    n_cmp++; if (v !== 8'd0) begin n_mis++; $display("FAIL clear_octets: got %0d expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_runt();
    test_good();
    test_oversize();
    test_sfd_err();
    test_midframe_reset();
    test_clkena();
    test_boundaries();
    test_saturation();
    test_clear_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
